sw_debounce: RTL
================

Name: sw_debounce

Overview:
Conditions the eight raw board slide switches before they reach the SoC top-level `sw` inputs. It sits directly upstream of the SoC wrapper, clocked by `sys_clk`.
- Synchronises each asynchronous switch bit with a 2-flop chain.
- Debounces each bit with an independent stability counter.
- Emits per-bit rise/fall pulses and a sticky change-pending flag with acknowledge, so firmware-visible switches never glitch.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before accepting a new level (1 ms at 50 MHz); legal range 1 .. 2^CNT_W.
- CNT_W, 16, width of each per-bit counter.

Ports:
- sys_clk  in  1  sole clock.
- RSTn  in  1  reset, synchronous, active-low.
- sw_raw  in  WIDTH  asynchronous switch pins.
- sw_stable  out  WIDTH  debounced level, drives SoC `sw`.
- sw_rise  out  WIDTH  1-cycle pulse per bit when its stable level goes 0->1.
- sw_fall  out  WIDTH  1-cycle pulse per bit when its stable level goes 1->0.
- sw_change  out  1  1-cycle pulse, OR of all rise/fall bits.
- evt_pending  out  1  sticky flag, set by any change.
- evt_ack  in  1  synchronous clear of evt_pending.

Behaviour:
- All state is updated only on the sys_clk rising edge. Reset takes effect on the first edge with RSTn=0 and holds while low.
- Reset values: sync flops 0, counters 0, sw_stable 0, sw_rise 0, sw_fall 0, sw_change 0, evt_pending 0.
- Synchroniser: s1 <= sw_raw; s2 <= s1. Logic below uses s2 only.
- Per-bit counter, for each bit i:
  - If s2[i] == sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= s2[i]; cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A single cycle of agreement (glitch) restarts the count from 0.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Latency: a raw level first sampled at edge k, and held, appears on sw_stable after edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges inclusive.
  - DEBOUNCE_CYCLES=1 gives 3 edges.
  - A pulse shorter than DEBOUNCE_CYCLES+2 edges never reaches sw_stable.
- Edge outputs are registered and assert in the same cycle sw_stable first shows the new value, for exactly one cycle:
  - sw_rise[i] <= s2[i] & ~sw_stable[i] & update[i].
  - sw_fall[i] <= ~s2[i] & sw_stable[i] & update[i].
  - Multiple bits may update in the same cycle; each gets its own pulse.
- sw_change is registered: OR of the next-state rise|fall, so it is coincident with them.
- evt_pending:
  - Set on any cycle where any bit updates (coincident with sw_change).
  - Cleared by evt_ack=1.
  - Simultaneous update and evt_ack: set wins, so evt_pending stays 1.
  - evt_ack while already clear has no effect.
- Post-reset: switches already high are treated as changes. They produce sw_rise pulses and set evt_pending after DEBOUNCE_CYCLES+2 edges.
- Reset mid-count discards all partial counts. Any pulse in flight is cleared on the reset edge.
- The block contains no combinational path from any input to any output.

Test Plan:
- Use DEBOUNCE_CYCLES=4 throughout.
- Reset, then set sw_raw=8'h00 → all outputs 0 for 20 cycles; evt_pending=0.
- Set sw_raw[0] 0->1 at edge k and hold → sw_stable=8'h01 after edge k+5. sw_rise=8'h01 and sw_change=1 for that one cycle only; evt_pending=1 from then until acked.
- Glitch bit 3: high for 4 edges, low 1 edge, high again → the count restarts. sw_stable[3] rises exactly 6 edges after the final 0->1 sample; no pulse before that.
- Set sw_raw=8'hF0 from 8'h00 in one cycle, then back to 8'h00 after 10 cycles:
  - sw_rise=8'hF0 in a single cycle.
  - Later sw_fall=8'hF0 in a single cycle.
  - sw_change pulses twice.
- Assert evt_ack in the same cycle an update occurs → evt_pending stays 1. An ack on the next cycle → evt_pending 0 the following cycle.
- Assert RSTn=0 for 1 edge while a bit's count is at 2 → all outputs 0 on that edge. After release, the bit, if still held, needs a full 6 edges to update.

Source files
------------

// File: rtl/sw_debounce.sv
// Switch conditioner: 2-flop synchroniser plus per-bit stability counter,
// with registered rise/fall pulses and a sticky acknowledgeable change flag.
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             sys_clk,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change,
    output logic             evt_pending,
    input  logic             evt_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_stable_q, sw_stable_d;
    logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
    logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
    logic             sw_change_q, sw_change_d;
    logic             evt_pending_q, evt_pending_d;
    logic [WIDTH-1:0] update;

    always_comb begin
        s1_d          = sw_raw;
        s2_d          = s1_q;
        sw_stable_d   = sw_stable_q;
        update        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Any cycle of agreement restarts the count, so glitches never accumulate.
            if (s2_q[i] != sw_stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    update[i]      = 1'b1;
                    sw_stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        sw_rise_d   = s2_q & ~sw_stable_q & update;
        sw_fall_d   = ~s2_q & sw_stable_q & update;
        sw_change_d = |(sw_rise_d | sw_fall_d);
        // A new change must never be lost to a concurrent acknowledge.
        if (|update) begin
            evt_pending_d = 1'b1;
        end else if (evt_ack) begin
            evt_pending_d = 1'b0;
        end else begin
            evt_pending_d = evt_pending_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!RSTn) begin
            s1_q          <= '0;
            s2_q          <= '0;
            sw_stable_q   <= '0;
            sw_rise_q     <= '0;
            sw_fall_q     <= '0;
            sw_change_q   <= 1'b0;
            evt_pending_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            sw_stable_q   <= sw_stable_d;
            sw_rise_q     <= sw_rise_d;
            sw_fall_q     <= sw_fall_d;
            sw_change_q   <= sw_change_d;
            evt_pending_q <= evt_pending_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable   = sw_stable_q;
    assign sw_rise     = sw_rise_q;
    assign sw_fall     = sw_fall_q;
    assign sw_change   = sw_change_q;
    assign evt_pending = evt_pending_q;

endmodule
